// File: rtl/cheshire_soc_fixture.sv
// cheshire_soc_fixture: SoC-side bring-up harness (reset sequencer, boot strap, EOC register, UART RX monitor, HDMI hsync)
// Ports: clk_i/rst_i (sync, active-high); boot_mode_i/_o strap and latched copy; soc_rst_o/reset_done_o SoC reset;
//   reg_* register port (0 SCRATCH/EOC, 1 BOOT, 2 STATUS, 3 reserved); eoc_o/exit_code_o program result;
//   uart_rx_i and uart_* 8N1 receiver outputs; axi2hdmi_hsync_o active-low horizontal sync.
// Build option: define CHESHIRE_FIXTURE_HSYNC_EN to build the hsync pixel counter, otherwise hsync is tied high.
module cheshire_soc_fixture #(
  parameter int ResetCycles = 16,
  parameter int ClkPerBit   = 16,
  parameter int HActive     = 640,
  parameter int HFront      = 16,
  parameter int HSync       = 96,
  parameter int HBack       = 48
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  boot_mode_i,
  output logic [1:0]  boot_mode_o,
  output logic        soc_rst_o,
  output logic        reset_done_o,
  input  logic        reg_valid_i,
  input  logic        reg_write_i,
  input  logic [1:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_ready_o,
  output logic [31:0] reg_rdata_o,
  output logic        eoc_o,
  output logic [31:0] exit_code_o,
  input  logic        uart_rx_i,
  output logic        uart_reading_byte_o,
  output logic [7:0]  uart_byte_o,
  output logic        uart_byte_valid_o,
  output logic        axi2hdmi_hsync_o
);
  localparam int RW = $clog2(ResetCycles + 1);
  localparam int CW = $clog2(ClkPerBit);
  localparam int HTotal = HActive + HFront + HSync + HBack;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  logic [RW-1:0] rst_cnt;
  logic [31:0] scratch;
  logic [2:0] rx_sync;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic byte_ok;
  logic scratch_wr;
  logic rx;
  assign reg_ready_o = reg_valid_i;
  assign scratch_wr = reg_valid_i & reg_write_i & (reg_addr_i == 2'd0);
  assign rx = rx_sync[1];
  assign uart_reading_byte_o = state_q != IDLE;
  always_comb
    reg_rdata_o = reg_addr_i == 2'd0 ? scratch :
                  reg_addr_i == 2'd1 ? {30'b0, boot_mode_o} :
                  reg_addr_i == 2'd2 ? {29'b0, uart_reading_byte_o, eoc_o, reset_done_o} : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_mode_o  <= boot_mode_i;
      soc_rst_o    <= 1'b1;
      reset_done_o <= 1'b0;
      rst_cnt      <= '0;
    end else if (soc_rst_o) begin
      if (rst_cnt == RW'(ResetCycles - 1)) begin
        soc_rst_o    <= 1'b0;
        reset_done_o <= 1'b1;
      end else rst_cnt <= rst_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scratch     <= '0;
      eoc_o       <= 1'b0;
      exit_code_o <= '0;
    end else if (scratch_wr) begin
      scratch <= reg_wdata_i;
      if (reg_wdata_i[0]) begin
        eoc_o       <= 1'b1;
        exit_code_o <= {1'b0, reg_wdata_i[31:1]};
      end
    end
  end
  // rx_sync[2] is the previous synchronized sample, used only for falling-edge detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx && rx_sync[2]) state_d = START;
      end
      START: if (cnt_q == CW'(ClkPerBit / 2 - 1)) begin
        cnt_d   = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (cnt_q == CW'(ClkPerBit - 1)) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == CW'(ClkPerBit - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
        byte_ok = rx;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync           <= 3'b111;
      state_q           <= IDLE;
      cnt_q             <= '0;
      bit_q             <= '0;
      shift_q           <= '0;
      uart_byte_o       <= '0;
      uart_byte_valid_o <= 1'b0;
    end else begin
      rx_sync           <= {rx_sync[1:0], uart_rx_i};
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      bit_q             <= bit_d;
      shift_q           <= shift_d;
      uart_byte_valid_o <= byte_ok;
      if (byte_ok) uart_byte_o <= shift_q;
    end
  end
`ifdef CHESHIRE_FIXTURE_HSYNC_EN
  localparam int PW = $clog2(HTotal);
  logic [PW-1:0] pix_q, pix_d;
  always_comb pix_d = pix_q == PW'(HTotal - 1) ? '0 : pix_q + 1'b1;
  // hsync is decoded from the next count so it lines up with the registered counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q            <= '0;
      axi2hdmi_hsync_o <= 1'b1;
    end else if (reset_done_o) begin
      pix_q            <= pix_d;
      axi2hdmi_hsync_o <= !(pix_d >= PW'(HActive + HFront) && pix_d < PW'(HActive + HFront + HSync));
    end
  end
`else
  // constant 1 for any legal line timing
  assign axi2hdmi_hsync_o = HTotal != 0;
`endif
endmodule

// File: tb/tb_cheshire_soc_fixture.sv
// tb_cheshire_soc_fixture: directed self-checking bench with a UART byte scoreboard
module tb_cheshire_soc_fixture;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  boot_mode_i = 2'd2;
  logic [1:0]  boot_mode_o;
  logic        soc_rst_o;
  logic        reset_done_o;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [1:0]  reg_addr_i = 2'd0;
  logic [31:0] reg_wdata_i = '0;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        eoc_o;
  logic [31:0] exit_code_o;
  logic        uart_rx_i = 1'b1;
  logic        uart_reading_byte_o;
  logic [7:0]  uart_byte_o;
  logic        uart_byte_valid_o;
  logic        axi2hdmi_hsync_o;
  int total = 0;
  int bad = 0;
  int n_valid = 0;
  logic [7:0] sb[$];
  cheshire_soc_fixture dut (
    .clk_i(clk_i), .rst_i(rst_i), .boot_mode_i(boot_mode_i), .boot_mode_o(boot_mode_o),
    .soc_rst_o(soc_rst_o), .reset_done_o(reset_done_o), .reg_valid_i(reg_valid_i),
    .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .eoc_o(eoc_o), .exit_code_o(exit_code_o),
    .uart_rx_i(uart_rx_i), .uart_reading_byte_o(uart_reading_byte_o), .uart_byte_o(uart_byte_o),
    .uart_byte_valid_o(uart_byte_valid_o), .axi2hdmi_hsync_o(axi2hdmi_hsync_o)
  );
  initial forever #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = a;
    reg_wdata_i = d;
    cyc(1);
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = a;
    #1;
    chk({tag, "_ready"}, reg_ready_o, 1);
    chk(tag, reg_rdata_o, exp);
    reg_valid_i = 1'b0;
  endtask
  task automatic send(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = f[i];
      cyc(16);
    end
    uart_rx_i = 1'b1;
  endtask
  // releases rst_i and checks the 16-cycle SoC reset window, with a scratch write inside it
  task automatic rst_release(input string tag, input logic [1:0] later_boot);
    rst_i = 1'b0;
    boot_mode_i = later_boot;
    for (int i = 1; i <= 16; i++) begin
      reg_valid_i = i == 3;
      reg_write_i = i == 3;
      reg_addr_i  = 2'd0;
      reg_wdata_i = 32'h10;
      cyc(1);
      if (i == 3) chk({tag, "_scratch_in_soc_rst"}, reg_rdata_o, 32'h10);
      if (i == 15) chk({tag, "_soc_rst_c15"}, {reset_done_o, soc_rst_o}, 2'b01);
      if (i == 16) chk({tag, "_soc_rst_c16"}, {reset_done_o, soc_rst_o}, 2'b10);
    end
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask
  always @(negedge clk_i)
    if (uart_byte_valid_o) begin
      n_valid++;
      if (sb.size() == 0) chk("uart_unexpected", uart_byte_valid_o, 0);
      else chk("uart_byte_sb", uart_byte_o, sb.pop_front());
    end
  initial begin
    int v0;
    cyc(5);
    chk("rst_soc_rst", soc_rst_o, 1);
    chk("rst_done", reset_done_o, 0);
    chk("rst_eoc", eoc_o, 0);
    chk("rst_exit", exit_code_o, 0);
    chk("rst_boot", boot_mode_o, 2);
    chk("rst_hsync", axi2hdmi_hsync_o, 1);
    chk("rst_uart", {uart_reading_byte_o, uart_byte_valid_o, uart_byte_o}, 0);
    rst_release("seq1", 2'd0);
`ifdef CHESHIRE_FIXTURE_HSYNC_EN
    begin
      int f1 = 0, f2 = 0, r1 = 0;
      logic prev = 1'b1;
      for (int k = 1; k <= 1460; k++) begin
        cyc(1);
        if (prev && !axi2hdmi_hsync_o) begin
          if (f1 == 0) f1 = k;
          else if (f2 == 0) f2 = k;
        end
        if (!prev && axi2hdmi_hsync_o && r1 == 0) r1 = k;
        prev = axi2hdmi_hsync_o;
      end
      chk("hsync_fall1", f1, 656);
      chk("hsync_fall2", f2, 1456);
      chk("hsync_low_width", r1 - f1, 96);
    end
`else
    begin
      int not_high = 0;
      for (int k = 0; k < 2000; k++) begin
        cyc(1);
        if (axi2hdmi_hsync_o !== 1'b1) not_high++;
      end
      chk("hsync_const_high", not_high, 0);
    end
`endif
    rd(2'd1, 32'd2, "boot_latched");
    rd(2'd2, 32'd1, "status_done");
    wr(2'd0, 32'h1);
    chk("eoc1_flag", eoc_o, 1);
    chk("eoc1_exit", exit_code_o, 0);
    wr(2'd0, 32'h7);
    chk("eoc7_exit", exit_code_o, 3);
    wr(2'd0, 32'h2);
    chk("noeoc_flag", eoc_o, 1);
    chk("noeoc_exit", exit_code_o, 3);
    rd(2'd0, 32'h2, "scratch_rd");
    rd(2'd2, 32'd3, "status_eoc");
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, 32'd0, "addr3_rd");
    rd(2'd0, 32'h2, "scratch_after_a3");
    v0 = n_valid;
    sb.push_back(8'h5A);
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = i == 0 ? 1'b0 : i == 9 ? 1'b1 : 8'h5A >> (i - 1);
      cyc(16);
      if (i == 0) chk("uart_busy_start", uart_reading_byte_o, 1);
      if (i == 8) chk("uart_busy_data", uart_reading_byte_o, 1);
      if (i == 9) chk("uart_busy_after_stop", uart_reading_byte_o, 0);
    end
    cyc(4);
    chk("uart_one_pulse", n_valid - v0, 1);
    chk("uart_byte", uart_byte_o, 8'h5A);
    rd(2'd2, 32'd3, "status_uart_idle");
    v0 = n_valid;
    uart_rx_i = 1'b0;
    cyc(3);
    uart_rx_i = 1'b1;
    chk("glitch_busy_set", uart_reading_byte_o, 1);
    cyc(7);
    chk("glitch_busy_pre_mid", uart_reading_byte_o, 1);
    cyc(1);
    chk("glitch_busy_drop", uart_reading_byte_o, 0);
    cyc(30);
    chk("glitch_no_pulse", n_valid - v0, 0);
    send({1'b0, 8'hC3, 1'b0});
    cyc(8);
    chk("frame_err_no_pulse", n_valid - v0, 0);
    chk("frame_err_byte_kept", uart_byte_o, 8'h5A);
    chk("frame_err_idle", uart_reading_byte_o, 0);
    wr(2'd0, 32'hFF);
    chk("mid_eoc_exit", exit_code_o, 32'h7F);
    uart_rx_i = 1'b0;
    cyc(40);
    chk("mid_busy", uart_reading_byte_o, 1);
    rst_i = 1'b1;
    uart_rx_i = 1'b1;
    boot_mode_i = 2'd1;
    cyc(1);
    chk("mid_soc_rst", {soc_rst_o, reset_done_o}, 2'b10);
    chk("mid_eoc", eoc_o, 0);
    chk("mid_exit", exit_code_o, 0);
    chk("mid_uart", {uart_reading_byte_o, uart_byte_valid_o, uart_byte_o}, 0);
    chk("mid_hsync", axi2hdmi_hsync_o, 1);
    rd(2'd0, 32'd0, "mid_scratch");
    cyc(2);
    rst_release("seq2", 2'd3);
    rd(2'd1, 32'd1, "boot_relatched");
    cyc(200);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
